conv_window_gen: RTL and testbench

//  Sliding-window generator for the conv/pool datapath. Accepts a raster-order pixel stream of one
//  MxM feature map and presents the full KxK window, all K*K pixels in parallel, to the

---
 rtl/cnn_pkg.sv | 14 +
 rtl/line_delay_en.sv | 40 ++++
 rtl/conv_window_gen.sv | 123 ++++++++++++
 tb/tb_conv_window_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the conv/pool datapath and the window packing helper.
// Blocks take these as parameter defaults so one frame geometry is used everywhere.
package cnn_pkg;

  localparam int DW = 16;
  localparam int M  = 28;
  localparam int K  = 3;

  // Flat slot of window pixel (r,c); k defaults to the datapath window size.
  function automatic int win_idx(input int r, input int c, input int k = K);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_delay_en.sv
// Enable-gated shift-register line delay: DEPTH accepted beats from din to dout.
// A zero-depth delay is a plain wire, which covers the K == M corner.
module line_delay_en #(
  parameter int DEPTH = 25,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, reset, en};
    assign dout      = din;
  end else begin : g_shift
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
      mem_d = mem_q;
      if (en) begin
        mem_d[0] = din;
        for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
      end
    end

    // NOTE: the storage is cleared on reset so that a frame aborted mid-way leaves no
    // stale pixels behind; most buffers could skip this, these cannot.
    always_ff @(posedge clk) begin
      if (reset) mem_q <= '{default: '0};
      else       mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];
  end

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a raster-order MxM pixel stream.
// K-1 line delays feed the upper window rows; windows are flagged only at legal strided positions.
module conv_window_gen #(
  parameter int M      = cnn_pkg::M,
  parameter int K      = cnn_pkg::K,
  parameter int STRIDE = 1,
  parameter int DW     = cnn_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_pixel,
  output logic              win_valid,
  output logic [K*K*DW-1:0] win_data,
  output logic              frame_done
);

  localparam int CW   = $clog2(M);
  localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LAST = K - 1 + STRIDE * ((M - K) / STRIDE);

  localparam logic [CW-1:0] POS_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] POS_LAST  = CW'(LAST);
  localparam logic [CW-1:0] POS_END   = CW'(M - 1);
  localparam logic [PW-1:0] PH_END    = PW'(STRIDE - 1);

  logic [DW-1:0]     win_q [K][K];
  logic [DW-1:0]     win_d [K][K];
  logic [DW-1:0]     dly_out [K-1];
  logic [CW-1:0]     row_q, row_d, col_q, col_d;
  logic [PW-1:0]     cph_q, cph_d, rph_q, rph_d;
  logic [PW-1:0]     cph_cur, rph_cur;
  logic              legal;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [K*K*DW-1:0] win_data_q, win_data_d;

  // Delay j is fed by the pixel leaving the left edge of window row K-1-j.
  for (genvar j = 0; j < K - 1; j++) begin : g_line
    line_delay_en #(
      .DEPTH(M - K),
      .WIDTH(DW)
    ) u_line (
      .clk  (clk),
      .reset(reset),
      .en   (in_valid),
      .din  (win_q[K-1-j][0]),
      .dout (dly_out[j])
    );
  end

  // Stride phases restart at the first legal column/row, so no modulo is needed.
  assign cph_cur = (col_q == POS_FIRST) ? '0 : cph_q;
  assign rph_cur = (row_q == POS_FIRST) ? '0 : rph_q;
  assign legal   = in_valid && (row_q >= POS_FIRST) && (col_q >= POS_FIRST) &&
                   (cph_cur == '0) && (rph_cur == '0);

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    win_d        = win_q;
    row_d        = row_q;
    col_d        = col_q;
    cph_d        = cph_q;
    rph_d        = rph_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_data_d   = win_data_q;

    if (in_valid) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      for (int r = 0; r < K - 1; r++) win_d[r][K-1] = dly_out[K-2-r];
      win_d[K-1][K-1] = in_pixel;

      cph_d = (cph_cur == PH_END) ? '0 : cph_cur + PW'(1);
      if (col_q == POS_END) begin
        col_d = '0;
        row_d = (row_q == POS_END) ? '0 : row_q + CW'(1);
        rph_d = (rph_cur == PH_END) ? '0 : rph_cur + PW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (legal) begin
        win_valid_d  = 1'b1;
        frame_done_d = (row_q == POS_LAST) && (col_q == POS_LAST);
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            win_data_d[DW*cnn_pkg::win_idx(r, c, K) +: DW] = win_d[r][c];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q        <= '{default: '0};
      row_q        <= '0;
      col_q        <= '0;
      cph_q        <= '0;
      rph_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
    end else begin
      win_q        <= win_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cph_q        <= cph_d;
      rph_q        <= rph_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_data_q   <= win_data_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_data   = win_data_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: three configurations (28/3/1, 28/2/2, 5/3/1), each with
// a raster-position reference model checking every output cycle, plus per-scenario checks.
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_a [3];
  logic [15:0] p_a [3];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CM   = (g == 2) ? 5 : 28;
    localparam int CK   = (g == 1) ? 2 : 3;
    localparam int CS   = (g == 1) ? 2 : 1;
    localparam int LAST = CK - 1 + CS * ((CM - CK) / CS);

    logic                 win_valid, frame_done;
    logic [CK*CK*16-1:0]  win_data;

    conv_window_gen #(
      .M(CM), .K(CK), .STRIDE(CS), .DW(16)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (v_a[g]),
      .in_pixel  (p_a[g]),
      .win_valid (win_valid),
      .win_data  (win_data),
      .frame_done(frame_done)
    );

    int          tr = 0, tc = 0;
    int          n_win = 0, n_done = 0, n_err = 0, n_spur = 0;
    int          min_pix = 65536;
    logic        exp_v = 1'b0, exp_d = 1'b0, exp_f = 1'b0, prev_beat = 1'b0;
    logic [15:0] img     [CM][CM];
    logic [15:0] exp_w   [CK*CK];
    logic [15:0] first_w [CK*CK];
    logic [15:0] last_w  [CK*CK];

    // Outputs seen at a falling edge belong to the beat presented one falling edge earlier.
    always @(negedge clk) begin
      if (win_valid !== exp_v || frame_done !== exp_d) begin
        n_err++;
        if (n_err < 5) $display("[TB] cfg%0d flag error pos(%0d,%0d) valid=%b/%b done=%b/%b",
                                g, tr, tc, win_valid, exp_v, frame_done, exp_d);
      end
      if (win_valid === 1'b1) begin
        if (!prev_beat) n_spur++;
        n_win++;
        if (frame_done === 1'b1) n_done++;
        for (int i = 0; i < CK * CK; i++) begin
          if (exp_v && win_data[16*i +: 16] !== exp_w[i]) begin
            n_err++;
            if (n_err < 5) $display("[TB] cfg%0d pixel %0d got %0d want %0d",
                                    g, i, win_data[16*i +: 16], exp_w[i]);
          end
          if (int'(win_data[16*i +: 16]) < min_pix) min_pix = int'(win_data[16*i +: 16]);
          if (exp_f) first_w[i] = win_data[16*i +: 16];
          if (frame_done === 1'b1) last_w[i] = win_data[16*i +: 16];
        end
      end

      prev_beat = 1'b0;
      exp_v     = 1'b0;
      exp_d     = 1'b0;
      exp_f     = 1'b0;
      if (reset === 1'b1) begin
        tr      = 0;
        tc      = 0;
        min_pix = 65536;
      end else if (v_a[g] === 1'b1) begin
        prev_beat   = 1'b1;
        img[tr][tc] = p_a[g];
        if (tr >= CK - 1 && tc >= CK - 1 && (tr - CK + 1) % CS == 0 && (tc - CK + 1) % CS == 0) begin
          exp_v = 1'b1;
          exp_d = (tr == LAST && tc == LAST);
          exp_f = (tr == CK - 1 && tc == CK - 1);
          for (int r = 0; r < CK; r++)
            for (int c = 0; c < CK; c++)
              exp_w[r*CK+c] = img[tr-CK+1+r][tc-CK+1+c];
        end
        if (tc == CM - 1) begin
          tc = 0;
          tr = (tr == CM - 1) ? 0 : tr + 1;
        end else begin
          tc = tc + 1;
        end
      end
    end
  end

  function automatic logic [143:0] exp_pack(input int off, input int k, input int m);
    logic [143:0] v;
    v = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        v[16*(r*k+c) +: 16] = 16'(off + r * m + c);
    return v;
  endfunction

  task automatic drive(input int g, input logic v, input logic [15:0] p);
    @(posedge clk);
    #1;
    v_a[g] = v;
    p_a[g] = p;
  endtask

  task automatic stream(input int g, input int off, input int from, input int to, input int gap);
    for (int p = from; p <= to; p++) begin
      repeat (gap) drive(g, 1'b0, 16'h0);
      drive(g, 1'b1, 16'(off + p));
    end
  endtask

  task automatic idle(input int g, input int n);
    repeat (n) drive(g, 1'b0, 16'h0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(0, 3);
    reset = 1'b0;
    idle(0, 2);
    tests_run++;
    if (cfg[0].win_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got %b want 0", cfg[0].win_valid);
    end
    tests_run++;
    if (cfg[0].frame_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done got %b want 0", cfg[0].frame_done);
    end
    tests_run++;
    if (cfg[0].win_data !== '0) begin
      tests_failed++; $display("FAIL reset_data got %h want 0", cfg[0].win_data);
    end
    tests_run++;
    if (cfg[1].win_valid !== 1'b0 || cfg[1].win_data !== '0) begin
      tests_failed++; $display("FAIL reset_cfg1 got %b/%h want 0/0", cfg[1].win_valid, cfg[1].win_data);
    end
    tests_run++;
    if (cfg[2].win_valid !== 1'b0 || cfg[2].win_data !== '0) begin
      tests_failed++; $display("FAIL reset_cfg2 got %b/%h want 0/0", cfg[2].win_valid, cfg[2].win_data);
    end
  endtask

  task automatic test_contiguous;
    int n0, d0, e0;
    logic [143:0] e, held;
    n0 = cfg[0].n_win; d0 = cfg[0].n_done; e0 = cfg[0].n_err;
    e  = exp_pack(0, 3, 28);
    stream(0, 0, 0, 58, 0);
    drive(0, 1'b0, 16'h0);
    tests_run++;
    if (cfg[0].win_valid !== 1'b1 || cfg[0].n_win != n0) begin
      tests_failed++;
      $display("FAIL first_window_latency got valid=%b earlier=%0d want valid=1 earlier=0",
               cfg[0].win_valid, cfg[0].n_win - n0);
    end
    tests_run++;
    if (cfg[0].win_data !== e) begin
      tests_failed++; $display("FAIL first_window_data got %h want %h", cfg[0].win_data, e);
    end
    held = cfg[0].win_data;
    drive(0, 1'b0, 16'h0);
    tests_run++;
    if (cfg[0].win_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_valid got %b want 0", cfg[0].win_valid);
    end
    tests_run++;
    if (cfg[0].win_data !== held) begin
      tests_failed++; $display("FAIL idle_hold got %h want %h", cfg[0].win_data, held);
    end
    stream(0, 0, 59, 783, 0);
    idle(0, 3);
    tests_run++;
    if (cfg[0].n_win - n0 != 676) begin
      tests_failed++; $display("FAIL contig_count got %0d want 676", cfg[0].n_win - n0);
    end
    tests_run++;
    if (cfg[0].n_done - d0 != 1) begin
      tests_failed++; $display("FAIL contig_done got %0d want 1", cfg[0].n_done - d0);
    end
    tests_run++;
    if (cfg[0].n_err != e0) begin
      tests_failed++; $display("FAIL contig_model got %0d errors want 0", cfg[0].n_err - e0);
    end
  endtask

  task automatic test_gapped;
    int n0, d0, e0, s0;
    n0 = cfg[0].n_win; d0 = cfg[0].n_done; e0 = cfg[0].n_err; s0 = cfg[0].n_spur;
    stream(0, 0, 0, 783, 2);
    idle(0, 3);
    tests_run++;
    if (cfg[0].n_win - n0 != 676) begin
      tests_failed++; $display("FAIL gapped_count got %0d want 676", cfg[0].n_win - n0);
    end
    tests_run++;
    if (cfg[0].n_done - d0 != 1) begin
      tests_failed++; $display("FAIL gapped_done got %0d want 1", cfg[0].n_done - d0);
    end
    tests_run++;
    if (cfg[0].n_spur != s0) begin
      tests_failed++; $display("FAIL gapped_spurious got %0d want 0", cfg[0].n_spur - s0);
    end
    tests_run++;
    if (cfg[0].n_err != e0) begin
      tests_failed++; $display("FAIL gapped_model got %0d errors want 0", cfg[0].n_err - e0);
    end
  endtask

  task automatic test_stride2;
    int n0, d0, e0;
    logic [143:0] e;
    logic [15:0]  want_last [4];
    logic         bad;
    n0 = cfg[1].n_win; d0 = cfg[1].n_done; e0 = cfg[1].n_err;
    e  = exp_pack(0, 2, 28);
    stream(1, 0, 0, 29, 0);
    drive(1, 1'b0, 16'h0);
    tests_run++;
    if (cfg[1].win_valid !== 1'b1) begin
      tests_failed++; $display("FAIL s2_first_valid got %b want 1", cfg[1].win_valid);
    end
    tests_run++;
    if (cfg[1].win_data !== e[63:0]) begin
      tests_failed++; $display("FAIL s2_first_data got %h want %h", cfg[1].win_data, e[63:0]);
    end
    stream(1, 0, 30, 783, 0);
    idle(1, 3);
    tests_run++;
    if (cfg[1].n_win - n0 != 196) begin
      tests_failed++; $display("FAIL s2_count got %0d want 196", cfg[1].n_win - n0);
    end
    tests_run++;
    if (cfg[1].n_done - d0 != 1) begin
      tests_failed++; $display("FAIL s2_done got %0d want 1", cfg[1].n_done - d0);
    end
    want_last = '{16'd754, 16'd755, 16'd782, 16'd783};
    bad = 1'b0;
    for (int i = 0; i < 4; i++) if (cfg[1].last_w[i] !== want_last[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL s2_last_window got {%0d,%0d,%0d,%0d} want {754,755,782,783}",
               cfg[1].last_w[0], cfg[1].last_w[1], cfg[1].last_w[2], cfg[1].last_w[3]);
    end
    tests_run++;
    if (cfg[1].n_err != e0) begin
      tests_failed++; $display("FAIL s2_model got %0d errors want 0", cfg[1].n_err - e0);
    end
  endtask

  task automatic test_mid_reset;
    int e0;
    logic [143:0] e;
    stream(0, 0, 0, 100, 0);
    drive(0, 1'b0, 16'h0);
    reset = 1'b1;
    drive(0, 1'b0, 16'h0);
    reset = 1'b0;
    e0 = cfg[0].n_err;
    e  = exp_pack(1000, 3, 28);
    stream(0, 1000, 0, 58, 0);
    drive(0, 1'b0, 16'h0);
    tests_run++;
    if (cfg[0].win_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rst_first_valid got %b want 1", cfg[0].win_valid);
    end
    tests_run++;
    if (cfg[0].win_data !== e) begin
      tests_failed++; $display("FAIL rst_first_data got %h want %h", cfg[0].win_data, e);
    end
    stream(0, 1000, 59, 783, 0);
    idle(0, 3);
    tests_run++;
    if (cfg[0].min_pix < 1000) begin
      tests_failed++; $display("FAIL rst_stale_pixel got min %0d want >=1000", cfg[0].min_pix);
    end
    tests_run++;
    if (cfg[0].n_err != e0) begin
      tests_failed++; $display("FAIL rst_model got %0d errors want 0", cfg[0].n_err - e0);
    end
  endtask

  task automatic test_back_to_back;
    int d0, e0;
    logic bad;
    d0 = cfg[0].n_done; e0 = cfg[0].n_err;
    stream(0, 0, 0, 783, 0);
    stream(0, 2000, 0, 783, 0);
    idle(0, 3);
    tests_run++;
    if (cfg[0].n_done - d0 != 2) begin
      tests_failed++; $display("FAIL b2b_done got %0d want 2", cfg[0].n_done - d0);
    end
    bad = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (cfg[0].first_w[r*3+c] !== 16'(2000 + r * 28 + c)) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL b2b_first_window got top-left %0d bottom-right %0d want 2000 and 2058",
               cfg[0].first_w[0], cfg[0].first_w[8]);
    end
    tests_run++;
    if (cfg[0].n_err != e0) begin
      tests_failed++; $display("FAIL b2b_model got %0d errors want 0", cfg[0].n_err - e0);
    end
  endtask

  task automatic test_small_frame;
    int n0, d0, e0;
    logic bad;
    logic [15:0] want_last [9];
    n0 = cfg[2].n_win; d0 = cfg[2].n_done; e0 = cfg[2].n_err;
    stream(2, 0, 0, 24, 0);
    idle(2, 3);
    tests_run++;
    if (cfg[2].n_win - n0 != 9) begin
      tests_failed++; $display("FAIL m5_count got %0d want 9", cfg[2].n_win - n0);
    end
    tests_run++;
    if (cfg[2].n_done - d0 != 1) begin
      tests_failed++; $display("FAIL m5_done got %0d want 1", cfg[2].n_done - d0);
    end
    want_last = '{16'd12, 16'd13, 16'd14, 16'd17, 16'd18, 16'd19, 16'd22, 16'd23, 16'd24};
    bad = 1'b0;
    for (int i = 0; i < 9; i++) if (cfg[2].last_w[i] !== want_last[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL m5_last_window got top-left %0d bottom-right %0d want 12 and 24",
               cfg[2].last_w[0], cfg[2].last_w[8]);
    end
    tests_run++;
    if (cfg[2].n_err != e0) begin
      tests_failed++; $display("FAIL m5_model got %0d errors want 0", cfg[2].n_err - e0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v_a[i] = 1'b0;
      p_a[i] = 16'h0;
    end
    test_reset;
    test_contiguous;
    test_gapped;
    test_stride2;
    test_mid_reset;
    test_back_to_back;
    test_small_frame;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
